// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: data width, the receive
// controller state encoding and the per-cycle frame classification.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      OFF = 2'd0,
      RUN = 2'd1,
      GAP = 2'd2
   } rx_ctrl_state_t;

   typedef enum logic [1:0] {
      FC_NONE   = 2'd0,
      FC_GOOD   = 2'd1,
      FC_PARITY = 2'd2,
      FC_STOP   = 2'd3
   } frame_class_t;

   // A bad stop bit outranks everything, including a coincident rx_valid;
   // parity is only meaningful when rx_valid qualifies it.
   function automatic frame_class_t classify_frame(input logic valid,
                                                   input logic parity_err,
                                                   input logic stop_err);
      frame_class_t c;
      if (stop_err) begin
         c = FC_STOP;
      end else if (valid && parity_err) begin
         c = FC_PARITY;
      end else if (valid) begin
         c = FC_GOOD;
      end else begin
         c = FC_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous byte FIFO with simultaneous push/pop and an occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   i_push, i_push_data  write request and byte
//   i_pop              read request (ignored when empty)
//   o_head             byte at the head of the queue
//   o_empty, o_full    status flags
//   o_level            occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [UART_DATA_W-1:0]   i_push_data,
   input  logic                     i_pop,
   output logic [UART_DATA_W-1:0]   o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [UART_DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [LW-1:0]          r_level;
   logic                   w_push_ok;
   logic                   w_pop_ok;

   assign o_empty   = (r_level == LW'(0));
   assign o_full    = (r_level == LW'(DEPTH));
   assign w_pop_ok  = i_pop && !o_empty;
   // When full, the write slot equals the head slot; the head is read out
   // this cycle, so overwriting it at the edge is safe.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller: classifies frame events, buffers good bytes,
// keeps saturating parity/stop error counters and a sticky overrun flag,
// and pulses idle_irq when the line goes quiet after a burst of bytes.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   enable                               frame intake enable
//   rx_data, rx_valid, rx_parity_err,
//   rx_stop_err                          receiver frame-event inputs
//   err_clear                            clear counters and overrun
//   rd_data, rd_valid, rd_ready          FIFO read port (valid/ready)
//   fifo_level                           occupancy 0..DEPTH
//   overrun, parity_cnt, stop_cnt        error status
//   idle_irq                             one-cycle idle-gap pulse
// ---------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int IDLE_CYCLES = 2048,
   parameter int CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [UART_DATA_W-1:0]   rx_data,
   input  logic                     rx_valid,
   input  logic                     rx_parity_err,
   input  logic                     rx_stop_err,
   input  logic                     err_clear,
   output logic [UART_DATA_W-1:0]   rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overrun,
   output logic [CNT_W-1:0]         parity_cnt,
   output logic [CNT_W-1:0]         stop_cnt,
   output logic                     idle_irq
);

   localparam int             CW        = $clog2(IDLE_CYCLES);
   localparam logic [CW-1:0]  IDLE_LAST = CW'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   rx_ctrl_state_t r_state, w_state_nxt;
   frame_class_t   w_class;
   logic [CW-1:0]  r_idle_cnt, w_idle_cnt_nxt;
   logic           r_idle_irq, w_irq;
   logic           r_overrun;
   logic [CNT_W-1:0] r_parity_cnt, r_stop_cnt;
   logic           w_empty, w_full, w_pop, w_good, w_drop, w_push_acc;

   // Frame events are ignored entirely while the controller is OFF.
   always_comb begin
      if (r_state != OFF) begin
         w_class = classify_frame(rx_valid, rx_parity_err, rx_stop_err);
      end else begin
         w_class = FC_NONE;
      end
   end

   assign w_good     = (w_class == FC_GOOD);
   assign w_pop      = rd_ready && !w_empty;
   assign w_drop     = w_good && w_full && !w_pop;
   assign w_push_acc = w_good && !w_drop;

   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_good),
      .i_push_data (rx_data),
      .i_pop       (w_pop),
      .o_head      (rd_data),
      .o_empty     (w_empty),
      .o_full      (w_full),
      .o_level     (fifo_level)
   );

   assign rd_valid = !w_empty;

   // Error counters and sticky overrun; a coincident event beats err_clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity_cnt <= '0;
         r_stop_cnt   <= '0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_class == FC_PARITY) begin
            if (r_parity_cnt == CNT_MAX) r_parity_cnt <= CNT_MAX;
            else if (err_clear)          r_parity_cnt <= CNT_W'(1);
            else                         r_parity_cnt <= r_parity_cnt + CNT_W'(1);
         end else if (err_clear) begin
            r_parity_cnt <= '0;
         end
         if (w_class == FC_STOP) begin
            if (r_stop_cnt == CNT_MAX) r_stop_cnt <= CNT_MAX;
            else if (err_clear)        r_stop_cnt <= CNT_W'(1);
            else                       r_stop_cnt <= r_stop_cnt + CNT_W'(1);
         end else if (err_clear) begin
            r_stop_cnt <= '0;
         end
         if (w_drop)         r_overrun <= 1'b1;
         else if (err_clear) r_overrun <= 1'b0;
      end
   end

   assign parity_cnt = r_parity_cnt;
   assign stop_cnt   = r_stop_cnt;
   assign overrun    = r_overrun;

   // FSM state, idle counter and registered irq.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= OFF;
         r_idle_cnt <= '0;
         r_idle_irq <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
         r_idle_irq <= w_irq;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = OFF;
      end else begin
         case (r_state)
            OFF:     w_state_nxt = RUN;
            RUN:     w_state_nxt = w_push_acc ? GAP : RUN;
            GAP: begin
               if (w_push_acc)                   w_state_nxt = GAP;
               else if (r_idle_cnt == IDLE_LAST) w_state_nxt = RUN;
               else                              w_state_nxt = GAP;
            end
            default: w_state_nxt = OFF;
         endcase
      end
   end

   // Idle counter update and end-of-gap detection.
   always_comb begin
      w_irq          = 1'b0;
      w_idle_cnt_nxt = '0;
      if (!enable) begin
         w_idle_cnt_nxt = '0;
      end else begin
         case (r_state)
            GAP: begin
               if (w_push_acc) begin
                  w_idle_cnt_nxt = '0;
               end else if (r_idle_cnt == IDLE_LAST) begin
                  w_irq = 1'b1;
               end else begin
                  w_idle_cnt_nxt = r_idle_cnt + CW'(1);
               end
            end
            default: w_idle_cnt_nxt = '0;
         endcase
      end
   end

   assign idle_irq = r_idle_irq;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sits directly behind the UART receiver and in front of the host/bus interface. It classifies each completed frame reported by the receiver, buffers good bytes in a small FIFO with a valid/ready read port, and keeps saturating error counters and a sticky overrun flag. It raises a one-cycle idle interrupt when the line goes quiet after a burst of bytes.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `IDLE_CYCLES`, 2048: clk cycles without an accepted byte, after at least one accepted byte, before `idle_irq`; ≥2.
- `CNT_W`, 8: width of each error counter.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: frame intake enable; FIFO read side works regardless.
- `rx_data` in 8: byte from receiver, valid in the frame-event cycle.
- `rx_valid` in 1: one-cycle pulse, frame ended with good stop bit.
- `rx_parity_err` in 1: parity mismatch, qualified by `rx_valid`.
- `rx_stop_err` in 1: one-cycle pulse, frame ended with bad stop bit.
- `err_clear` in 1: one-cycle clear of counters and `overrun`.
- `rd_data` out 8: FIFO head byte.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts head; pop when `rd_valid && rd_ready`.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overrun` out 1: sticky; good byte arrived with FIFO full and no pop.
- `parity_cnt` out CNT_W: saturating count of parity-error frames.
- `stop_cnt` out CNT_W: saturating count of stop-error frames.
- `idle_irq` out 1: one-cycle pulse at end of idle gap.

## Operation
- Frame event = `rx_valid | rx_stop_err`, counted only when FSM is not OFF.
- Classification, priority order: `rx_stop_err` → `stop_cnt`+1, byte discarded (also if `rx_valid` is asserted in the same cycle); `rx_valid && rx_parity_err` → `parity_cnt`+1, discarded; `rx_valid` alone → good byte, push.
- Push with FIFO full: if a pop occurs in the same cycle, the push is accepted and the level stays DEPTH; otherwise the byte is dropped and `overrun` is set.
- Pop on empty is a no-op. Pointers wrap modulo DEPTH.
- Counters saturate at all-ones and never wrap.
- `err_clear` coincident with an event: the event wins. The counter loads 1 (or stays at all-ones if saturated), or `overrun` stays 1. Other counters clear.
- FSM states:
  - OFF: intake ignored, idle counter held at 0. Go to RUN when `enable`=1.
  - RUN: waiting for the first good byte. On an accepted push, go to GAP and set idle counter to 0.
  - GAP: idle counter +1 per cycle; an accepted push resets it to 0. When counter == IDLE_CYCLES-1 with no push that cycle, pulse `idle_irq` and go to RUN.
  - Any state goes to OFF when `enable`=0. No `idle_irq` fires for an interrupted gap. FIFO contents are retained.
- Dropped (overrun), parity and stop frames do not restart the idle counter.

## Timing
- Reset values: `rd_valid`=0, `fifo_level`=0, `overrun`=0, counters=0, `idle_irq`=0, `rd_data`=0. FSM is in OFF and all pointers are 0.
- Push in cycle N: `rd_valid`/`fifo_level` update at the edge ending N and are visible in N+1. Latency is 1 cycle.
- `rd_data` is registered/array output. It is stable while `rd_valid && !rd_ready`.
- Counters and `overrun` update at the edge ending the event cycle.
- `idle_irq` asserts in the cycle after the counter reaches IDLE_CYCLES-1. It is high for exactly 1 cycle.
- Reset mid-operation clears the FIFO, counters and FSM immediately, asynchronously. A partially counted gap produces no irq.

## Structure
- Shared `uart_pkg`: `UART_DATA_W`=8, the `rx_ctrl_state_t` enum (OFF, RUN, GAP) and the frame-class encoding.
- One sub-module `uart_rx_fifo`: synchronous FIFO (DEPTH, 8-bit, level output, full/empty, simultaneous push/pop). Classification, counters and the FSM stay in `uart_rx_ctrl`.

## Test plan
- Reset then `enable`=1; push 0x55, 0xA3 (good frames), `rd_ready`=1 → `rd_data` 0x55 then 0xA3, each valid 1 cycle after push, level returns to 0.
- 9 good bytes 0x00..0x08, `rd_ready`=0, DEPTH=8 → level 8, `overrun`=1, reads give 0x00..0x07; repeat with pop on the 9th cycle → no overrun, 0x08 retained.
- Parity-error frame 0x12 and stop-error frame 0x34 → `parity_cnt`=1, `stop_cnt`=1, FIFO empty; 300 stop errors with CNT_W=8 → `stop_cnt`=255.
- `err_clear` same cycle as a parity error with `parity_cnt`=5, `stop_cnt`=3 → `parity_cnt`=1, `stop_cnt`=0, `overrun`=0.
- IDLE_CYCLES=16: good byte at cycle 0 → single `idle_irq` pulse 16 cycles later; second byte at cycle 10 → irq moves to 16 cycles after it; `enable`=0 mid-gap → no irq.
- Assert `reset_n`=0 with level 5 mid-gap → outputs at reset values immediately, no `idle_irq` after release.
